// File: rtl/subt_arbiter.sv
// Round-robin sequencer sharing one registered subtractor among NREQ requesters; results return id-tagged via an in-order FIFO.
// Result 2 cycles after grant; issue is credit-gated on FIFO space. Optional macro SUBT_ARB_PRIO_EN gives requester 0 strict priority.
module subt_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 16,
  parameter int IDW   = 2,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      sub_a,
  output logic [W-1:0]      sub_b,
  input  logic [W-1:0]      sub_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_data
);

`ifdef SUBT_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   dat;
  } res_t;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           inflight_v_q, inflight_v_d;
  logic [IDW-1:0] inflight_id_q, inflight_id_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  res_t           mem_q [DEPTH];
  res_t           mem_d [DEPTH];

  logic           credit;
  logic           grant_vld;
  logic [IDW-1:0] winner;
  logic           push;
  logic           pop;
  res_t           head;

  function automatic int rr_idx(input int base, input int k);
    int t;
    t = base + k;
    if (t >= NREQ) t = t - NREQ;
    return t;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ops in flight count against FIFO space so a push can never find it full.
  always_comb begin
    credit    = (int'(count_q) + int'(inflight_v_q)) < DEPTH;
    grant_vld = 1'b0;
    winner    = '0;
    if (PRIO_EN && req_valid[0]) begin
      grant_vld = 1'b1;
    end
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_vld && req_valid[i] && (i == rr_idx(int'(rr_ptr_q), k)) &&
            !(PRIO_EN && i == 0)) begin
          grant_vld = 1'b1;
          winner    = IDW'(i);
        end
      end
    end
    grant_vld = grant_vld && credit && rst_n;
  end

  always_comb begin
    req_ready = '0;
    sub_a     = '0;
    sub_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && winner == IDW'(i)) begin
        req_ready[i] = 1'b1;
        sub_a        = req_a[i*W +: W];
        sub_b        = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    inflight_v_d  = grant_vld;
    inflight_id_d = grant_vld ? winner : inflight_id_q;
    rr_ptr_d      = rr_ptr_q;
    // Under strict priority, requester 0 wins do not disturb the rotation among the rest.
    if (grant_vld && !(PRIO_EN && winner == '0)) begin
      rr_ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  assign res_valid = (count_q != '0);
  assign push      = inflight_v_q;
  assign pop       = res_valid && res_ready;
  assign head      = mem_q[rd_ptr_q];
  assign res_id    = res_valid ? head.id  : '0;
  assign res_data  = res_valid ? head.dat : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{id: inflight_id_q, dat: sub_y};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      inflight_v_q  <= 1'b0;
      inflight_id_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      inflight_v_q  <= inflight_v_d;
      inflight_id_q <= inflight_id_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
